// File: rtl/button_gesture_pkg.sv
// Shared definitions for the button gesture classifier.
//   - Legacy 3-bit state codes, plus the state enum built on those codes
//   - gesture_cnt_width(): counter width wide enough for the largest interval
package button_gesture_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        WAIT2  = ST_WAIT2,
        PRESS2 = ST_PRESS2,
        LONG   = ST_LONG
    } state_e;

    function automatic int unsigned gesture_cnt_width(input int unsigned l,
                                                      input int unsigned d,
                                                      input int unsigned r);
        int unsigned m;
        m = l;
        if (d > m) m = d;
        if (r > m) m = r;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_gesture_timer.sv
// gesture_timer: free-running interval counter for the gesture FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment enable
//   limit      : runtime compare value
//   hit        : high while cnt == limit
module gesture_timer #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [width_p-1:0] limit,
    output logic               hit
);

    logic [width_p-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/button_gesture.sv
// button_gesture: classifies debounced press/release pulses into gestures.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   down_i, up_i    : one-cycle press / release pulses from the debouncer
//   held_o          : high while in PRESS1, PRESS2 or LONG
//   short_o         : single short press
//   double_o        : double click
//   long_o          : hold threshold reached
//   repeat_o        : auto-repeat tick while held long
// All outputs are registered; gesture pulses are one cycle wide and appear
// the cycle after the deciding event.
module button_gesture
    import button_gesture_pkg::*;
#(
    parameter int unsigned long_cycles_p   = 50_000_000,
    parameter int unsigned dclick_cycles_p = 15_000_000,
    parameter int unsigned repeat_cycles_p = 10_000_000
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic down_i,
    input  logic up_i,
    output logic held_o,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned cnt_width_p =
        gesture_cnt_width(long_cycles_p, dclick_cycles_p, repeat_cycles_p);

    localparam logic [cnt_width_p-1:0] long_lim   = cnt_width_p'(long_cycles_p - 1);
    localparam logic [cnt_width_p-1:0] dclick_lim = cnt_width_p'(dclick_cycles_p - 1);
    localparam logic [cnt_width_p-1:0] repeat_lim = cnt_width_p'(repeat_cycles_p - 1);

    state_e                 state, next_state;
    logic                   clr, en, hit;
    logic [cnt_width_p-1:0] limit;
    logic                   short_n, double_n, long_n, repeat_n;
    logic                   down_v, up_v;

    // Simultaneous down/up is a protocol violation: drop both.
    assign down_v = down_i & ~up_i;
    assign up_v   = up_i & ~down_i;
    assign en     = (state != IDLE);

    gesture_timer #(
        .width_p (cnt_width_p)
    ) u_timer (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .clr   (clr),
        .en    (en),
        .limit (limit),
        .hit   (hit)
    );

    // Button events take priority over a coinciding timer hit in every state.
    always_comb begin
        next_state = state;
        clr        = 1'b0;
        limit      = '0;
        short_n    = 1'b0;
        double_n   = 1'b0;
        long_n     = 1'b0;
        repeat_n   = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (down_v) next_state = PRESS1;
            end
            PRESS1: begin
                limit = long_lim;
                if (up_v) begin
                    next_state = WAIT2;
                    clr        = 1'b1;
                end else if (hit) begin
                    next_state = LONG;
                    clr        = 1'b1;
                    long_n     = 1'b1;
                end
            end
            WAIT2: begin
                limit = dclick_lim;
                if (down_v) begin
                    next_state = PRESS2;
                    clr        = 1'b1;
                end else if (hit) begin
                    next_state = IDLE;
                    clr        = 1'b1;
                    short_n    = 1'b1;
                end
            end
            PRESS2: begin
                limit = long_lim;
                if (up_v) begin
                    next_state = IDLE;
                    clr        = 1'b1;
                    double_n   = 1'b1;
                end else if (hit) begin
                    next_state = LONG;
                    clr        = 1'b1;
                    long_n     = 1'b1;
                end
            end
            LONG: begin
                limit = repeat_lim;
                if (up_v) begin
                    next_state = IDLE;
                    clr        = 1'b1;
                end else if (hit) begin
                    clr      = 1'b1;
                    repeat_n = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                clr        = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            held_o   <= 1'b0;
            short_o  <= 1'b0;
            double_o <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
        end else begin
            state    <= next_state;
            held_o   <= (next_state == PRESS1) || (next_state == PRESS2) ||
                        (next_state == LONG);
            short_o  <= short_n;
            double_o <= double_n;
            long_o   <= long_n;
            repeat_o <= repeat_n;
        end
    end

    a_no_simultaneous_events : assert property (
        @(posedge clk_i) disable iff (!reset_ni) !(down_i && up_i)
    ) else $warning("button_gesture: down_i and up_i asserted in the same cycle");

    a_one_gesture_pulse : assert property (
        @(posedge clk_i) disable iff (!reset_ni)
        $onehot0({short_o, double_o, long_o, repeat_o})
    ) else $error("button_gesture: more than one gesture pulse in a cycle");

endmodule

// File: tb/tb_button_gesture.sv
// Directed, table-driven bench for button_gesture with L=8, D=4, R=3.
// Each table row is a scenario: per-cycle masks of input pulses and of the
// expected value of every output, indexed by cycle number (cycle 0 = first
// cycle of the row). A hand-written sequence covers mid-gesture reset.
module tb_button_gesture;

    localparam int unsigned L = 8;
    localparam int unsigned D = 4;
    localparam int unsigned R = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic down = 1'b0;
    logic up = 1'b0;
    logic held, short_p, double_p, long_p, repeat_p;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    button_gesture #(
        .long_cycles_p   (L),
        .dclick_cycles_p (D),
        .repeat_cycles_p (R)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .down_i   (down),
        .up_i     (up),
        .held_o   (held),
        .short_o  (short_p),
        .double_o (double_p),
        .long_o   (long_p),
        .repeat_o (repeat_p)
    );

    typedef struct {
        string       name;
        int unsigned ncyc;
        logic [31:0] dn;
        logic [31:0] upm;
        logic [31:0] held;
        logic [31:0] shrt;
        logic [31:0] dbl;
        logic [31:0] lng;
        logic [31:0] rep;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] b(input int n);
        return rng(n, n);
    endfunction

    task automatic check(input string name, input int cyc, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    task automatic check_all(input string name, input int cyc, input logic [4:0] exp);
        check({name, ".held_o"},   cyc, held,     exp[4]);
        check({name, ".short_o"},  cyc, short_p,  exp[3]);
        check({name, ".double_o"}, cyc, double_p, exp[2]);
        check({name, ".long_o"},   cyc, long_p,   exp[1]);
        check({name, ".repeat_o"}, cyc, repeat_p, exp[0]);
    endtask

    task automatic run_vec(input vec_t v);
        for (int c = 0; c < int'(v.ncyc); c++) begin
            @(posedge clk);
            #1;
            check_all(v.name, c, {v.held[c], v.shrt[c], v.dbl[c], v.lng[c], v.rep[c]});
            down = v.dn[c];
            up   = v.upm[c];
        end
        down = 1'b0;
        up   = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"short",        12, b(0),         b(3),         rng(1,3),
                   b(8), '0, '0, '0};
        tbl[1] = '{"double",       12, b(0)|b(5),    b(3)|b(7),    rng(1,3)|rng(6,7),
                   '0, b(8), '0, '0};
        tbl[2] = '{"long_repeat",  25, b(0),         b(20),        rng(1,20),
                   '0, '0, b(9), b(12)|b(15)|b(18)};
        tbl[3] = '{"up_at_long",   16, b(0),         b(8),         rng(1,8),
                   b(13), '0, '0, '0};
        tbl[4] = '{"down_at_tmo",  16, b(0)|b(7),    b(3)|b(12),   rng(1,3)|rng(8,12),
                   '0, b(13), '0, '0};
        tbl[5] = '{"press2_long",  24, b(0)|b(5),    b(3)|b(20),   rng(1,3)|rng(6,20),
                   '0, '0, b(14), b(17)|b(20)};
        tbl[6] = '{"both_idle",     6, b(2),         b(2),         '0,
                   '0, '0, '0, '0};
        tbl[7] = '{"both_press1",  13, b(0)|b(2),    b(2)|b(5),    rng(1,5),
                   b(10), '0, '0, '0};
        tbl[8] = '{"ignored_evts", 13, b(3),         b(1)|b(5),    rng(4,5),
                   b(10), '0, '0, '0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 5'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // Reset in PRESS1: cycle 5 reset low, cycle 6 released, up in 10
        @(posedge clk);
        #1;
        check_all("mid_reset", 0, 5'b0);
        down = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            down = 1'b0;
            check_all("mid_reset", c, 5'b10000);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_all("mid_reset_async", 5, 5'b0);
        @(posedge clk);
        #1;
        check_all("mid_reset", 6, 5'b0);
        reset_n = 1'b1;
        for (int c = 7; c <= 25; c++) begin
            @(posedge clk);
            #1;
            check_all("mid_reset", c, 5'b0);
            up = (c == 10);
        end
        up = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
